// File: rtl/bcnn_filter_sched.sv
// bcnn_filter_sched: replays one binarized 3x3 window against a bank of
// binary filters through a single shared BCNN neuron, collects the 1-bit
// results as their tags leave the latency pipe, and emits one packed vector.
module bcnn_filter_sched #(
  parameter  int N_FILT = 8,
  parameter  int LAT    = 1,
  localparam int FW     = (N_FILT > 1) ? $clog2(N_FILT) : 1
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              cfg_we,
  input  logic [FW-1:0]     cfg_addr,
  input  logic [8:0]        cfg_weight,
  input  logic [3:0]        cfg_bias,
  input  logic              win_valid,
  output logic              win_ready,
  input  logic [8:0]        win_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_FILT-1:0] out_vec,
  output logic [8:0]        bc_data,
  output logic [8:0]        bc_weight,
  output logic [3:0]        bc_bias,
  input  logic              bc_result,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

  localparam logic [FW-1:0] LAST_F = FW'(N_FILT - 1);
  localparam logic [FW:0]   NUM_F  = (FW+1)'(N_FILT);

  state_t              state_q;
  logic [8:0]          wgt_q  [N_FILT];
  logic [3:0]          bias_q [N_FILT];
  logic [8:0]          win_q;
  logic [FW-1:0]       f_q;
  logic [FW-1:0]       f_d;
  logic [LAT-1:0]      tag_vld_q;
  logic [FW-1:0]       tag_idx_q [LAT];
  logic [N_FILT-1:0]   out_vec_q;
  logic                out_valid_q;
  logic [8:0]          bc_data_q;
  logic [8:0]          bc_weight_q;
  logic [3:0]          bc_bias_q;
  logic                cfg_ok;

  assign f_d       = f_q + FW'(1);
  assign cfg_ok    = cfg_we && (state_q == IDLE) && ({1'b0, cfg_addr} < NUM_F);

  assign win_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_vec   = out_vec_q;
  assign bc_data   = bc_data_q;
  assign bc_weight = bc_weight_q;
  assign bc_bias   = bc_bias_q;

  // Filter register file; only writable while idle so a window in flight
  // always sees one consistent set of weights.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      for (int i = 0; i < N_FILT; i++) begin
        wgt_q[i]  <= '0;
        bias_q[i] <= '0;
      end
    end else if (cfg_ok) begin
      wgt_q[cfg_addr]  <= cfg_weight;
      bias_q[cfg_addr] <= cfg_bias;
    end
  end

  // Scheduler FSM: issue one filter per cycle, tag each issue, capture the
  // neuron result when its tag falls out of the pipe, then hold the vector.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q     <= IDLE;
      win_q       <= '0;
      f_q         <= '0;
      tag_vld_q   <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_idx_q[i] <= '0;
      end
      out_vec_q   <= '0;
      out_valid_q <= 1'b0;
      bc_data_q   <= '0;
      bc_weight_q <= '0;
      bc_bias_q   <= '0;
    end else begin
      tag_vld_q[0] <= 1'b0;
      for (int i = 1; i < LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
      if (tag_vld_q[LAT-1]) begin
        out_vec_q[tag_idx_q[LAT-1]] <= bc_result;
      end
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            win_q     <= win_data;
            out_vec_q <= '0;
            f_q       <= '0;
            state_q   <= ISSUE;
          end
        end
        ISSUE: begin
          bc_data_q    <= win_q;
          bc_weight_q  <= wgt_q[f_q];
          bc_bias_q    <= bias_q[f_q];
          tag_vld_q[0] <= 1'b1;
          tag_idx_q[0] <= f_q;
          if (f_q == LAST_F) begin
            state_q <= DRAIN;
          end else begin
            f_q <= f_d;
          end
        end
        DRAIN: begin
          if (tag_vld_q == '0) begin
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcnn_filter_sched.sv
// tb_bcnn_filter_sched: drives two scheduler instances (8 filters / latency 1
// and 4 filters / latency 3) with mock BCNN neurons and compares every
// activation vector against a filter-bank model kept in the bench.
module tb_bcnn_filter_sched;

  localparam int NA = 8;
  localparam int LA = 1;
  localparam int NB = 4;
  localparam int LB = 3;

  int checks   = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rstA, rstB;

  logic          cfgWeA, winValidA, winReadyA, outValidA, outReadyA, bcResultA, busyA;
  logic [2:0]    cfgAddrA;
  logic [8:0]    cfgWeightA, winDataA, bcDataA, bcWeightA;
  logic [3:0]    cfgBiasA, bcBiasA;
  logic [NA-1:0] outVecA;

  logic          cfgWeB, winValidB, winReadyB, outValidB, outReadyB, bcResultB, busyB;
  logic [1:0]    cfgAddrB;
  logic [8:0]    cfgWeightB, winDataB, bcDataB, bcWeightB;
  logic [3:0]    cfgBiasB, bcBiasB;
  logic [NB-1:0] outVecB;

  logic          combB, d1B, d2B;

  logic [8:0]    mwA [NA];
  logic [3:0]    mbA [NA];
  logic [8:0]    mwB [NB];
  logic [3:0]    mbB [NB];

  always #5 clk = ~clk;

  bcnn_filter_sched #(.N_FILT(NA), .LAT(LA)) dutA (
    .clk_in(clk), .reset_in(rstA), .cfg_we(cfgWeA), .cfg_addr(cfgAddrA),
    .cfg_weight(cfgWeightA), .cfg_bias(cfgBiasA), .win_valid(winValidA),
    .win_ready(winReadyA), .win_data(winDataA), .out_valid(outValidA),
    .out_ready(outReadyA), .out_vec(outVecA), .bc_data(bcDataA),
    .bc_weight(bcWeightA), .bc_bias(bcBiasA), .bc_result(bcResultA), .busy(busyA)
  );

  bcnn_filter_sched #(.N_FILT(NB), .LAT(LB)) dutB (
    .clk_in(clk), .reset_in(rstB), .cfg_we(cfgWeB), .cfg_addr(cfgAddrB),
    .cfg_weight(cfgWeightB), .cfg_bias(cfgBiasB), .win_valid(winValidB),
    .win_ready(winReadyB), .win_data(winDataB), .out_valid(outValidB),
    .out_ready(outReadyB), .out_vec(outVecB), .bc_data(bcDataB),
    .bc_weight(bcWeightB), .bc_bias(bcBiasB), .bc_result(bcResultB), .busy(busyB)
  );

  // Mock neuron for instance A: combinational, so valid one edge after issue.
  assign bcResultA = ($countones(~(bcDataA ^ bcWeightA)) >= int'(bcBiasA));

  // Mock neuron for instance B: two extra register stages give three cycles.
  assign combB     = ($countones(~(bcDataB ^ bcWeightB)) >= int'(bcBiasB));
  always @(posedge clk) begin
    d1B <= combB;
    d2B <= d1B;
  end
  assign bcResultB = d2B;

  // Expected neuron output from the binary-neuron rule.
  function automatic logic neuron(input logic [8:0] d, input logic [8:0] w, input logic [3:0] b);
    return $countones(~(d ^ w)) >= int'(b);
  endfunction

  function automatic logic [NA-1:0] expectA(input logic [8:0] d);
    logic [NA-1:0] v;
    for (int f = 0; f < NA; f++) v[f] = neuron(d, mwA[f], mbA[f]);
    return v;
  endfunction

  function automatic logic [NB-1:0] expectB(input logic [8:0] d);
    logic [NB-1:0] v;
    for (int f = 0; f < NB; f++) v[f] = neuron(d, mwB[f], mbB[f]);
    return v;
  endfunction

  task automatic cfg_write_a(input int addr, input logic [8:0] w, input logic [3:0] b);
    cfgWeA = 1'b1; cfgAddrA = addr[2:0]; cfgWeightA = w; cfgBiasA = b;
    @(posedge clk); #1;
    cfgWeA = 1'b0;
    mwA[addr] = w; mbA[addr] = b;
  endtask

  task automatic cfg_write_b(input int addr, input logic [8:0] w, input logic [3:0] b);
    cfgWeB = 1'b1; cfgAddrB = addr[1:0]; cfgWeightB = w; cfgBiasB = b;
    @(posedge clk); #1;
    cfgWeB = 1'b0;
    mwB[addr] = w; mbB[addr] = b;
  endtask

  // Offer a window while idle, count cycles from the accept edge to out_valid
  // (lat stays -1 if it never comes) and optionally complete the handshake.
  task automatic run_window_a(input logic [8:0] d, input bit doRelease,
                              output logic [NA-1:0] vec, output int lat);
    winDataA = d; winValidA = 1'b1;
    @(posedge clk); #1;
    winValidA = 1'b0; cfgWeA = 1'b0; lat = -1;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      if (outValidA) begin lat = k; break; end
    end
    vec = outVecA;
    if (doRelease) begin
      outReadyA = 1'b1; @(posedge clk); #1; outReadyA = 1'b0;
    end
  endtask

  task automatic run_window_b(input logic [8:0] d, output logic [NB-1:0] vec, output int lat);
    winDataB = d; winValidB = 1'b1;
    @(posedge clk); #1;
    winValidB = 1'b0; lat = -1;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk); #1;
      if (outValidB) begin lat = k; break; end
    end
    vec = outVecB;
    outReadyB = 1'b1; @(posedge clk); #1; outReadyB = 1'b0;
  endtask

  task automatic test_reset;
    rstA = 1'b0; rstB = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cfgWeA = 1'($urandom); cfgAddrA = 3'($urandom); cfgWeightA = 9'($urandom); cfgBiasA = 4'($urandom);
      winValidA = 1'($urandom); winDataA = 9'($urandom); outReadyA = 1'($urandom);
      cfgWeB = 1'($urandom); cfgAddrB = 2'($urandom); cfgWeightB = 9'($urandom); cfgBiasB = 4'($urandom);
      winValidB = 1'($urandom); winDataB = 9'($urandom); outReadyB = 1'($urandom);
      @(posedge clk); #1;
    end
    checks++; if (outValidA !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid_a got=%0b exp=0", outValidA); end
    checks++; if (outVecA !== '0) begin failures++; $display("[TB] FAIL reset_out_vec_a got=%0h exp=0", outVecA); end
    checks++; if ({bcDataA, bcWeightA, bcBiasA} !== '0) begin failures++; $display("[TB] FAIL reset_bc_a got=%0h exp=0", {bcDataA, bcWeightA, bcBiasA}); end
    checks++; if (busyA !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy_a got=%0b exp=0", busyA); end
    checks++; if (winReadyA !== 1'b1) begin failures++; $display("[TB] FAIL reset_win_ready_a got=%0b exp=1", winReadyA); end
    checks++; if ({outValidB, outVecB, busyB, winReadyB} !== 6'b0_0000_0_1) begin failures++; $display("[TB] FAIL reset_status_b got=%0b exp=000001", {outValidB, outVecB, busyB, winReadyB}); end
    checks++; if ({bcDataB, bcWeightB, bcBiasB} !== '0) begin failures++; $display("[TB] FAIL reset_bc_b got=%0h exp=0", {bcDataB, bcWeightB, bcBiasB}); end
    cfgWeA = 0; winValidA = 0; outReadyA = 0; cfgWeB = 0; winValidB = 0; outReadyB = 0;
    for (int f = 0; f < NA; f++) begin mwA[f] = '0; mbA[f] = '0; end
    for (int f = 0; f < NB; f++) begin mwB[f] = '0; mbB[f] = '0; end
    rstA = 1'b1; rstB = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [NA-1:0] vec;
    int lat;
    cfg_write_a(0, 9'h1FF, 4'd9);
    cfg_write_a(1, 9'h000, 4'd1);
    for (int f = 2; f < NA; f++) cfg_write_a(f, 9'h1FF, 4'd0);
    run_window_a(9'h1FF, 1'b1, vec, lat);
    checks++; if (lat !== NA + LA + 1) begin failures++; $display("[TB] FAIL basic_latency got=%0d exp=%0d", lat, NA + LA + 1); end
    checks++; if (vec !== 8'b1111_1101) begin failures++; $display("[TB] FAIL basic_vec got=%b exp=11111101", vec); end
    repeat (3) begin @(posedge clk); #1; end
    checks++; if ({bcDataA, bcWeightA, bcBiasA} !== {9'h1FF, mwA[NA-1], mbA[NA-1]}) begin failures++; $display("[TB] FAIL idle_bc_hold got=%0h exp=%0h", {bcDataA, bcWeightA, bcBiasA}, {9'h1FF, mwA[NA-1], mbA[NA-1]}); end
    checks++; if ({busyA, winReadyA} !== 2'b01) begin failures++; $display("[TB] FAIL idle_status got=%b exp=01", {busyA, winReadyA}); end
  endtask

  task automatic test_backpressure;
    logic [NA-1:0] vec, held;
    logic [8:0] d;
    int lat;
    for (int f = 0; f < NA; f++) cfg_write_a(f, 9'($urandom), 4'($urandom_range(0, 10)));
    d = 9'($urandom);
    run_window_a(d, 1'b0, vec, lat);
    checks++; if (vec !== expectA(d)) begin failures++; $display("[TB] FAIL bp_vec got=%b exp=%b", vec, expectA(d)); end
    held = vec;
    for (int c = 0; c < 5; c++) begin
      winValidA = 1'b1; winDataA = 9'($urandom);
      @(posedge clk); #1;
      checks++; if ({outValidA, outVecA, winReadyA} !== {1'b1, held, 1'b0}) begin failures++; $display("[TB] FAIL bp_hold cycle=%0d got=%b exp=%b", c, {outValidA, outVecA, winReadyA}, {1'b1, held, 1'b0}); end
    end
    winValidA = 1'b0; outReadyA = 1'b1;
    @(posedge clk); #1;
    outReadyA = 1'b0;
    checks++; if ({outValidA, winReadyA, busyA} !== 3'b010) begin failures++; $display("[TB] FAIL bp_release got=%b exp=010", {outValidA, winReadyA, busyA}); end
    d = 9'($urandom);
    run_window_a(d, 1'b1, vec, lat);
    checks++; if (vec !== expectA(d) || lat !== NA + LA + 1) begin failures++; $display("[TB] FAIL bp_next got=%b/%0d exp=%b/%0d", vec, lat, expectA(d), NA + LA + 1); end
  endtask

  task automatic test_cfg_gating;
    logic [NA-1:0] vec;
    int lat;
    cfg_write_a(3, 9'h1FF, 4'd0);
    winDataA = 9'h1FF; winValidA = 1'b1;
    @(posedge clk); #1;
    winValidA = 1'b0;
    cfgWeA = 1'b1; cfgAddrA = 3'd3; cfgWeightA = 9'h000; cfgBiasA = 4'd9;
    @(posedge clk); #1;
    cfgWeA = 1'b0;
    lat = -1;
    for (int k = 2; k <= 64; k++) begin
      @(posedge clk); #1;
      if (outValidA) begin lat = k; break; end
    end
    vec = outVecA;
    checks++; if (lat !== NA + LA + 1) begin failures++; $display("[TB] FAIL gate_latency got=%0d exp=%0d", lat, NA + LA + 1); end
    checks++; if (vec[3] !== 1'b1 || vec !== expectA(9'h1FF)) begin failures++; $display("[TB] FAIL gate_busy_write got=%b exp=%b", vec, expectA(9'h1FF)); end
    outReadyA = 1'b1; @(posedge clk); #1; outReadyA = 1'b0;
    cfg_write_a(3, 9'h000, 4'd9);
    run_window_a(9'h1FF, 1'b1, vec, lat);
    checks++; if (vec[3] !== 1'b0 || vec !== expectA(9'h1FF)) begin failures++; $display("[TB] FAIL gate_idle_write got=%b exp=%b", vec, expectA(9'h1FF)); end
    cfgWeA = 1'b1; cfgAddrA = 3'd5; cfgWeightA = 9'h000; cfgBiasA = 4'd1;
    mwA[5] = 9'h000; mbA[5] = 4'd1;
    run_window_a(9'h1FF, 1'b1, vec, lat);
    checks++; if (vec[5] !== 1'b0 || vec !== expectA(9'h1FF)) begin failures++; $display("[TB] FAIL gate_same_cycle got=%b exp=%b", vec, expectA(9'h1FF)); end
  endtask

  task automatic test_random_a;
    logic [NA-1:0] vec;
    logic [8:0] d;
    int lat;
    for (int it = 0; it < 16; it++) begin
      for (int n = $urandom_range(0, 3); n > 0; n--) cfg_write_a($urandom_range(0, NA - 1), 9'($urandom), 4'($urandom_range(0, 10)));
      d = 9'($urandom);
      run_window_a(d, 1'b1, vec, lat);
      checks++; if (vec !== expectA(d) || lat !== NA + LA + 1) begin failures++; $display("[TB] FAIL rand_a it=%0d got=%b/%0d exp=%b/%0d", it, vec, lat, expectA(d), NA + LA + 1); end
    end
  endtask

  task automatic test_reset_mid_issue;
    logic [NA-1:0] vec;
    logic [8:0] d;
    int lat, seen;
    for (int f = 0; f < NA; f++) cfg_write_a(f, 9'($urandom), 4'd15);
    winDataA = 9'($urandom); winValidA = 1'b1;
    @(posedge clk); #1;
    winValidA = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstA = 1'b0;
    #1;
    checks++; if ({busyA, winReadyA, outValidA, outVecA} !== {3'b010, {NA{1'b0}}}) begin failures++; $display("[TB] FAIL midrst_status got=%b exp=%b", {busyA, winReadyA, outValidA, outVecA}, {3'b010, {NA{1'b0}}}); end
    @(posedge clk); #1;
    rstA = 1'b1;
    for (int f = 0; f < NA; f++) begin mwA[f] = '0; mbA[f] = '0; end
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (outValidA) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("[TB] FAIL midrst_no_out got=%0d exp=0", seen); end
    d = 9'($urandom);
    run_window_a(d, 1'b1, vec, lat);
    checks++; if (vec !== 8'hFF || vec !== expectA(d)) begin failures++; $display("[TB] FAIL midrst_regfile got=%b exp=11111111", vec); end
  endtask

  task automatic test_latency_param;
    logic [NB-1:0] vec;
    logic [8:0] d;
    int lat;
    cfg_write_b(0, 9'h000, 4'd1);
    cfg_write_b(1, 9'h1FF, 4'd9);
    cfg_write_b(2, 9'h000, 4'd1);
    cfg_write_b(3, 9'h1FF, 4'd9);
    run_window_b(9'h1FF, vec, lat);
    checks++; if (vec !== 4'b1010) begin failures++; $display("[TB] FAIL lat3_vec got=%b exp=1010", vec); end
    checks++; if (lat !== NB + LB + 1) begin failures++; $display("[TB] FAIL lat3_latency got=%0d exp=%0d", lat, NB + LB + 1); end
    for (int it = 0; it < 10; it++) begin
      for (int f = 0; f < NB; f++) cfg_write_b(f, 9'($urandom), 4'($urandom_range(0, 10)));
      d = 9'($urandom);
      run_window_b(d, vec, lat);
      checks++; if (vec !== expectB(d) || lat !== NB + LB + 1) begin failures++; $display("[TB] FAIL rand_b it=%0d got=%b/%0d exp=%b/%0d", it, vec, lat, expectB(d), NB + LB + 1); end
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rstA = 1'b0; rstB = 1'b0;
    cfgWeA = 0; cfgAddrA = 0; cfgWeightA = 0; cfgBiasA = 0; winValidA = 0; winDataA = 0; outReadyA = 0;
    cfgWeB = 0; cfgAddrB = 0; cfgWeightB = 0; cfgBiasB = 0; winValidB = 0; winDataB = 0; outReadyB = 0;
    #1;
    test_reset;
    test_basic;
    test_backpressure;
    test_cfg_gating;
    test_random_a;
    test_reset_mid_issue;
    test_latency_param;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
